// File: rtl/ffbank_pkg.sv
// ffbank_pkg: shared mode encoding for the multimode flip-flop bank.
//   ffbank_mode_t : 2-bit channel mode code
//   FFB_MODE_*    : D=00, T=01, JK=10, SR=11
package ffbank_pkg;

   typedef logic [1:0] ffbank_mode_t;

   localparam ffbank_mode_t FFB_MODE_D  = 2'b00;
   localparam ffbank_mode_t FFB_MODE_T  = 2'b01;
   localparam ffbank_mode_t FFB_MODE_JK = 2'b10;
   localparam ffbank_mode_t FFB_MODE_SR = 2'b11;

endpackage

// File: rtl/ffbank_cell.sv
// ffbank_cell: one run-time configurable D/T/JK/SR flip-flop channel.
//   clk, reset      : rising-edge clock, async active-high reset
//   en              : update enable; q holds when low
//   a, b            : primary/secondary inputs (D/T/J/S, -/-/K/R)
//   mode            : channel mode code
//   q               : channel state (registered)
//   illegal_evt_c   : combinational SR 11 event for this cycle (only when en)
module ffbank_cell
   import ffbank_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         a,
   input  logic         b,
   input  ffbank_mode_t mode,
   output logic         q,
   output logic         illegal_evt_c
);

   logic q_nxt;

   // Next-state selection by mode; SR 11 holds q and flags an event.
   always_comb begin
      q_nxt         = q;
      illegal_evt_c = 1'b0;
      case (mode)
         FFB_MODE_D: q_nxt = a;
         FFB_MODE_T: q_nxt = q ^ a;
         FFB_MODE_JK: begin
            case ({a, b})
               2'b01:   q_nxt = 1'b0;
               2'b10:   q_nxt = 1'b1;
               2'b11:   q_nxt = ~q;
               default: q_nxt = q;
            endcase
         end
         default: begin
            case ({a, b})
               2'b01:   q_nxt = 1'b0;
               2'b10:   q_nxt = 1'b1;
               2'b11:   illegal_evt_c = en;
               default: q_nxt = q;
            endcase
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)   q <= 1'b0;
      else if (en) q <= q_nxt;
   end

endmodule

// File: rtl/ffbank_multimode.sv
// ffbank_multimode: bank of WIDTH configurable flip-flop channels.
//   clk, reset   : rising-edge clock, async active-high reset
//   en           : global update enable
//   a, b         : per-channel inputs
//   cfg_we/ch/mode : mode-table write port (out-of-range channel ignored)
//   illegal_clr  : clears sticky illegal flags (a same-cycle event wins)
//   q, qn        : channel state and its complement
//   mode         : mode table, channel i at [2i+1:2i]
//   illegal      : sticky per-channel SR 11 flags
//   err_cnt      : saturating illegal-event count (macro FFBANK_ERR_CNT_EN)
module ffbank_multimode
   import ffbank_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   input  logic                     cfg_we,
   input  logic [$clog2(WIDTH)-1:0] cfg_ch,
   input  logic [1:0]               cfg_mode,
   input  logic                     illegal_clr,
   output logic [WIDTH-1:0]         q,
   output logic [WIDTH-1:0]         qn,
   output logic [2*WIDTH-1:0]       mode,
`ifdef FFBANK_ERR_CNT_EN
   output logic [CNT_W-1:0]         err_cnt,
`endif
   output logic [WIDTH-1:0]         illegal
);

   localparam int unsigned CH_W = $clog2(WIDTH);

   ffbank_mode_t     mode_tbl [WIDTH];
   logic [WIDTH-1:0] evt;

   // Channel instances and mode-table fan-out.
   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      ffbank_cell u_cell (
         .clk           (clk),
         .reset         (reset),
         .en            (en),
         .a             (a[i]),
         .b             (b[i]),
         .mode          (mode_tbl[i]),
         .q             (q[i]),
         .illegal_evt_c (evt[i])
      );
      assign mode[2*i +: 2] = mode_tbl[i];
   end

   assign qn = ~q;

   // Mode table; the cell sees the old entry on the write edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WIDTH; i++) mode_tbl[i] <= FFB_MODE_D;
      end else if (cfg_we) begin
         for (int i = 0; i < WIDTH; i++)
            if (32'(cfg_ch) == i) mode_tbl[i] <= cfg_mode;
      end
   end

   // Sticky flags: clear everything, then OR in this cycle's events.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) illegal <= '0;
      else       illegal <= (illegal_clr ? '0 : illegal) | evt;
   end

`ifdef FFBANK_ERR_CNT_EN
   localparam int unsigned SUM_W = CNT_W + 1;

   logic [SUM_W-1:0] pop_c;
   logic [SUM_W-1:0] sum_c;

   // Popcount of events added at one extra bit so overflow is visible.
   always_comb begin
      pop_c = '0;
      for (int i = 0; i < WIDTH; i++) pop_c = pop_c + SUM_W'(evt[i]);
      sum_c = SUM_W'(err_cnt) + pop_c;
   end

   // Saturating counter, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             err_cnt <= '0;
      else if (sum_c[CNT_W]) err_cnt <= '1;
      else                   err_cnt <= sum_c[CNT_W-1:0];
   end
`endif

   // cfg_ch is only compared against the loop index; keep its width tied.
   logic unused_ch_w;
   assign unused_ch_w = (CH_W == 0);

endmodule

// File: tb/tb_ffbank_multimode.sv
// Directed testbench for ffbank_multimode (WIDTH=8, CNT_W=8).
module tb_ffbank_multimode;
   import ffbank_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [7:0]  a, b;
   logic        cfg_we;
   logic [2:0]  cfg_ch;
   logic [1:0]  cfg_mode;
   logic        illegal_clr;
   logic [7:0]  q, qn, illegal;
   logic [15:0] mode;
`ifdef FFBANK_ERR_CNT_EN
   logic [7:0]  err_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ffbank_multimode #(.WIDTH(8), .CNT_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .a           (a),
      .b           (b),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_mode    (cfg_mode),
      .illegal_clr (illegal_clr),
      .q           (q),
      .qn          (qn),
      .mode        (mode),
`ifdef FFBANK_ERR_CNT_EN
      .err_cnt     (err_cnt),
`endif
      .illegal     (illegal)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mode(input logic [2:0] ch, input logic [1:0] m);
      en = 1'b0; cfg_we = 1'b1; cfg_ch = ch; cfg_mode = m;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic test_reset();
      en = 1'b1; a = 8'hFF; b = 8'h00;
      tick();
      checks++; if (q !== 8'hFF) begin failures++; $display("FAIL pre_reset_q got=%h exp=%h", q, 8'hFF); end
      en = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=%h", q, 8'h00); end
      checks++; if (qn !== 8'hFF) begin failures++; $display("FAIL reset_qn got=%h exp=%h", qn, 8'hFF); end
      checks++; if (illegal !== 8'h00) begin failures++; $display("FAIL reset_illegal got=%h exp=%h", illegal, 8'h00); end
      checks++; if (mode !== 16'h0000) begin failures++; $display("FAIL reset_mode got=%h exp=%h", mode, 16'h0000); end
`ifdef FFBANK_ERR_CNT_EN
      checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
`endif
      #1 reset = 1'b0;
   endtask

   task automatic test_d();
      en = 1'b1; a = 8'hA5; b = 8'h00;
      tick();
      checks++; if (q !== 8'hA5) begin failures++; $display("FAIL d_load got=%h exp=%h", q, 8'hA5); end
      en = 1'b0; a = 8'h00;
      tick();
      checks++; if (q !== 8'hA5) begin failures++; $display("FAIL d_hold got=%h exp=%h", q, 8'hA5); end
      checks++; if (qn !== 8'h5A) begin failures++; $display("FAIL d_qn got=%h exp=%h", qn, 8'h5A); end
   endtask

   task automatic test_t();
      logic [7:0] exp_q [4];
      exp_q[0] = 8'h08; exp_q[1] = 8'h00; exp_q[2] = 8'h08; exp_q[3] = 8'h00;
      set_mode(3'd3, FFB_MODE_T);
      checks++; if (mode !== 16'h0040) begin failures++; $display("FAIL t_mode got=%h exp=%h", mode, 16'h0040); end
      en = 1'b1; a = 8'h08; b = 8'h00;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (q !== exp_q[i]) begin failures++; $display("FAIL t_seq%0d got=%h exp=%h", i, q, exp_q[i]); end
      end
   endtask

   task automatic test_jk();
      logic [7:0] va [4];
      logic [7:0] vb [4];
      logic [7:0] exp_q [4];
      va[0] = 8'h01; vb[0] = 8'h00; exp_q[0] = 8'h01;
      va[1] = 8'h01; vb[1] = 8'h01; exp_q[1] = 8'h00;
      va[2] = 8'h01; vb[2] = 8'h01; exp_q[2] = 8'h01;
      va[3] = 8'h00; vb[3] = 8'h01; exp_q[3] = 8'h00;
      set_mode(3'd0, FFB_MODE_JK);
      checks++; if (mode !== 16'h0042) begin failures++; $display("FAIL jk_mode got=%h exp=%h", mode, 16'h0042); end
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = va[i]; b = vb[i];
         tick();
         checks++; if (q !== exp_q[i]) begin failures++; $display("FAIL jk_seq%0d got=%h exp=%h", i, q, exp_q[i]); end
      end
   endtask

   task automatic test_sr_saturate();
      for (int i = 0; i < 4; i++) set_mode(3'(i), FFB_MODE_SR);
      checks++; if (mode !== 16'h00FF) begin failures++; $display("FAIL sr_mode got=%h exp=%h", mode, 16'h00FF); end
      en = 1'b1; a = 8'h05; b = 8'h00;
      tick();
      checks++; if (q !== 8'h05) begin failures++; $display("FAIL sr_set got=%h exp=%h", q, 8'h05); end
      a = 8'h0F; b = 8'h0F;
      for (int i = 1; i <= 70; i++) begin
         tick();
`ifdef FFBANK_ERR_CNT_EN
         if (i == 1 || i == 63 || i == 64) begin
            checks++;
            if (err_cnt !== ((i == 64) ? 8'd255 : 8'(4 * i))) begin
               failures++; $display("FAIL sr_cnt_edge%0d got=%0d exp=%0d", i, err_cnt, (i == 64) ? 255 : 4 * i);
            end
         end
`endif
      end
      checks++; if (q !== 8'h05) begin failures++; $display("FAIL sr_hold got=%h exp=%h", q, 8'h05); end
      checks++; if (illegal !== 8'h0F) begin failures++; $display("FAIL sr_illegal got=%h exp=%h", illegal, 8'h0F); end
`ifdef FFBANK_ERR_CNT_EN
      checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL sr_sat got=%0d exp=255", err_cnt); end
`endif
      illegal_clr = 1'b1; a = 8'h00; b = 8'h00;
      tick();
      illegal_clr = 1'b0;
      checks++; if (illegal !== 8'h00) begin failures++; $display("FAIL sr_clr got=%h exp=%h", illegal, 8'h00); end
`ifdef FFBANK_ERR_CNT_EN
      checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL sr_clr_cnt got=%0d exp=255", err_cnt); end
`endif
      en = 1'b0; a = 8'h0F; b = 8'h0F;
      tick();
      checks++; if (illegal !== 8'h00) begin failures++; $display("FAIL sr_en0_illegal got=%h exp=%h", illegal, 8'h00); end
      checks++; if (q !== 8'h05) begin failures++; $display("FAIL sr_en0_q got=%h exp=%h", q, 8'h05); end
   endtask

   task automatic test_back_to_back();
      set_mode(3'd1, FFB_MODE_D);
      en = 1'b1; cfg_we = 1'b1; cfg_ch = 3'd1; cfg_mode = FFB_MODE_T; a = 8'h02; b = 8'h00;
      tick();
      cfg_we = 1'b0;
      checks++; if (q !== 8'h07) begin failures++; $display("FAIL race_old_mode got=%h exp=%h", q, 8'h07); end
      checks++; if (mode !== 16'h00F7) begin failures++; $display("FAIL race_mode got=%h exp=%h", mode, 16'h00F7); end
      tick();
      checks++; if (q !== 8'h05) begin failures++; $display("FAIL race_toggle got=%h exp=%h", q, 8'h05); end
      a = 8'h01; b = 8'h01;
      tick();
      checks++; if (illegal !== 8'h01) begin failures++; $display("FAIL race_evt0 got=%h exp=%h", illegal, 8'h01); end
      illegal_clr = 1'b1; a = 8'h04; b = 8'h04;
      tick();
      illegal_clr = 1'b0; en = 1'b0;
      checks++; if (illegal !== 8'h04) begin failures++; $display("FAIL race_clr_set got=%h exp=%h", illegal, 8'h04); end
      checks++; if (q !== 8'h05) begin failures++; $display("FAIL race_q got=%h exp=%h", q, 8'h05); end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; a = '0; b = '0;
      cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; illegal_clr = 1'b0;
      #12 reset = 1'b0;
      tick();
      test_reset();
      test_d();
      test_t();
      test_jk();
      test_sr_saturate();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ffbank_multimode.md
# ffbank_multimode

- Parametrised bank of `WIDTH` independent flip-flop channels.
- Each channel is configured at run time as a D, T, JK or SR flip-flop.
- SR `11` holds the channel's state deterministically and is flagged, instead of producing X.
- Sits wherever the design needs configurable state bits: control registers, handshake flags, test fixtures. Generalises the single fixed-function SR/D flip-flop to many channels and four modes, with error reporting.

## Interface
Parameters:
- `WIDTH`, default 8: number of channels, 2..64.
- `CNT_W`, default 8: width of the illegal-event counter.

Ports:
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: reset, asynchronous, active-high.
- `en`, in, 1: global update enable. When 0, all `q` hold.
- `a`, in, `WIDTH`: per-channel primary input. Meaning by mode: D=D, T=T, JK=J, SR=S.
- `b`, in, `WIDTH`: per-channel secondary input. Meaning by mode: JK=K, SR=R; ignored in D/T.
- `cfg_we`, in, 1: mode-table write strobe.
- `cfg_ch`, in, `$clog2(WIDTH)`: channel index to configure.
- `cfg_mode`, in, 2: mode code. 00=D, 01=T, 10=JK, 11=SR.
- `illegal_clr`, in, 1: clears the sticky `illegal` flags.
- `q`, out, `WIDTH`: channel state.
- `qn`, out, `WIDTH`: `~q`, combinational from `q`.
- `mode`, out, `2*WIDTH`: current mode table. Channel i occupies bits [2i+1:2i].
- `illegal`, out, `WIDTH`: sticky per-channel flag for SR `11`.
- `err_cnt`, out, `CNT_W`: saturating illegal-event count. Present only with the macro (see Configuration).

## Operation
- Reset values:
  - `q` = 0, `qn` = all ones.
  - Every mode entry = D (00).
  - `illegal` = 0, `err_cnt` = 0.
- Per channel i, on a clock edge with `en`=1, next state by mode:
  - D: `q <= a`.
  - T: `q <= q ^ a`.
  - JK: 00 hold, 01 (J=0, K=1) clear, 10 set, 11 toggle.
  - SR: 00 hold, 01 (S=0, R=1) clear, 10 set, 11 hold `q` and raise an illegal event.
- With `en`=0:
  - All `q` hold.
  - No illegal events are generated, even when SR inputs are `11`.
- Mode table:
  - When `cfg_we`=1, `mode[cfg_ch] <= cfg_mode` on the clock edge.
  - A `cfg_ch` value ≥ `WIDTH` is ignored; no entry changes.
- Illegal flags:
  - An illegal event on channel i sets `illegal[i]` on that edge.
  - `illegal_clr` zeroes all flags on the edge.
  - If an event and `illegal_clr` occur in the same cycle, set wins for that channel; all other channels clear.
- Arithmetic:
  - `err_cnt` adds the popcount of the cycle's illegal events.
  - The sum is computed at `CNT_W+1` bits and saturates at `2^CNT_W-1`; it never wraps.
  - `illegal_clr` does not affect `err_cnt`; only reset clears it.

## Timing
- Latency:
  - `q` updates one clock edge after `a`/`b` are sampled.
  - `qn`, `mode` and `illegal` are valid in the cycle after the edge.
- A mode write takes effect for data updates on the following edge. If `cfg_we` and a data update target the same channel in the same cycle, the data update uses the old mode.
- `reset` asserted mid-operation forces all reset values immediately, independent of `clk`. After deassertion, the first active edge behaves as if from power-on.
- No combinational path from `a`, `b` or `cfg_*` to any output.

## Configuration
- Macro: `FFBANK_ERR_CNT_EN`.
- Defined: the `err_cnt` port and its saturating popcount counter exist.
- Undefined: the port and its logic are removed. All other behaviour, including the `illegal` flags, is unchanged.

## Structure
- Package `ffbank_pkg` holds:
  - the 2-bit mode typedef `ffbank_mode_t`;
  - localparams `FFB_MODE_D`, `FFB_MODE_T`, `FFB_MODE_JK`, `FFB_MODE_SR`.
- Sub-module `ffbank_cell`: one channel.
  - Inputs: `a`, `b`, `mode`, `en`.
  - Contents: the `q` register and next-state logic.
  - Outputs: `q` and a 1-bit illegal event.
  - Instantiated `WIDTH` times with a generate loop.
- Top level holds the mode table, the sticky flags, and the popcount/saturating counter.

## Test plan
- Reset while `q`=8'hFF in D mode → `q`=0, `qn`=8'hFF, `illegal`=0 and `err_cnt`=0 immediately, without a clock edge.
- All channels D; drive `a`=8'hA5 with `en`=1, then `en`=0 with `a`=8'h00 → `q`=8'hA5 after one edge, and still 8'hA5 after the second.
- Channel 3 set to T with `a[3]`=1 for 4 edges → `q[3]` sequence 1,0,1,0. Other channels follow D behaviour.
- Channel 0 set to JK; apply J,K = 10, 11, 11, 01 → `q[0]` sequence 1,0,1,0.
- Channels 0–3 set to SR; apply S=R=1 on all four for 70 edges (`CNT_W`=8) → `q` holds, `illegal`[3:0]=4'hF, `err_cnt`=255 (saturated). Then `illegal_clr` with S=R=0 → flags clear, `err_cnt` stays 255.
- Same-cycle races:
  - `cfg_we` switches channel 1 to T in the same cycle as `a[1]`=1, with `q[1]`=0 → D semantics apply, `q[1]`=1. Next edge with `a[1]`=1 toggles to 0.
  - `illegal_clr` coinciding with a new SR `11` event on channel 2 → `illegal[2]` stays 1.
